sdram_wb_bridge: RTL and testbench

Wishbone slave front-end for `sdr_controller`, placed directly upstream of it in the user project. Decodes an 8 MB window, converts single Wishbone cycles into the controller's `in_valid`/`busy`/`out_valid` request protocol, and merges partial-byte writes by read-modify-write, since the controller has no byte masks. It also bounds read latency with a timeout so the bus can never hang.

---
 rtl/sdram_wb_bridge.sv | 171 +++++++++++++++++
 tb/tb_sdram_wb_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_bridge.sv
// Wishbone slave bridge onto the sdr_controller request/response protocol.
// Partial writes become read-modify-write; reads are bounded by a timeout.
module sdram_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [22:0] user_addr,
  output logic        rw,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  input  logic        busy,
  output logic        in_valid,
  input  logic        out_valid,
  output logic        err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] MERGE    = 3'd3;
  localparam logic [2:0] WR_ISSUE = 3'd4;
  localparam logic [2:0] ACK      = 3'd5;

  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic        we_r;
  logic [3:0]  sel_r;
  logic [31:0] wdat_r;
  logic [31:0] rdat_r;
  logic [7:0]  cnt_r;
  logic        hit_s;
  logic        accept_s;
  logic        timeout_s;
  logic        adr_unused_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] wdat,
                                              input logic [31:0] rdat,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = sel[n] ? wdat[8*n +: 8] : rdat[8*n +: 8];
    end
    return res;
  endfunction

  assign hit_s        = (wbs_adr_i[31:23] == BASE_ADDR[31:23]);
  assign accept_s     = (state_r == IDLE) && wbs_cyc_i && wbs_stb_i && hit_s;
  assign timeout_s    = (state_r == RD_WAIT) && !out_valid && (cnt_r == TIMEOUT_LAST);
  assign adr_unused_s = ^wbs_adr_i[1:0];

  // Request strobe: combinational so it rises in the first non-busy issue cycle.
  always_comb begin
    in_valid = 1'b0;
    if ((state_r == RD_ISSUE) || (state_r == WR_ISSUE)) begin
      in_valid = ~busy;
    end else begin
      in_valid = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (!wbs_we_i) begin
          state_s = RD_ISSUE;
        end else if (wbs_sel_i == 4'hF) begin
          state_s = WR_ISSUE;
        end else if (wbs_sel_i == 4'h0) begin
          state_s = ACK;
        end else begin
          state_s = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (!busy) state_s = RD_WAIT;
        else       state_s = RD_ISSUE;
      end
      RD_WAIT: begin
        if (out_valid)      state_s = we_r ? MERGE : ACK;
        else if (timeout_s) state_s = ACK;
        else                state_s = RD_WAIT;
      end
      MERGE:    state_s = WR_ISSUE;
      WR_ISSUE: begin
        if (!busy) state_s = ACK;
        else       state_s = WR_ISSUE;
      end
      ACK:      state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Read-wait timeout counter; cleared while the read is being issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (state_r == RD_ISSUE) begin
      cnt_r <= 8'd0;
    end else if (state_r == RD_WAIT) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Request capture and merge buffer; controller-side fields hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r      <= 1'b0;
      sel_r     <= 4'h0;
      wdat_r    <= 32'h0;
      rdat_r    <= 32'h0;
      user_addr <= 23'h0;
      rw        <= 1'b0;
      data_in   <= 32'h0;
    end else if (accept_s) begin
      we_r      <= wbs_we_i;
      sel_r     <= wbs_sel_i;
      wdat_r    <= wbs_dat_i;
      user_addr <= {wbs_adr_i[22:2], 2'b00};
      rw        <= wbs_we_i && (wbs_sel_i == 4'hF);
      if (wbs_we_i && (wbs_sel_i == 4'hF)) data_in <= wbs_dat_i;
    end else if ((state_r == RD_WAIT) && out_valid) begin
      rdat_r <= data_out;
    end else if (state_r == MERGE) begin
      data_in <= merge_bytes(wdat_r, rdat_r, sel_r);
      rw      <= 1'b1;
    end
  end

  // Wishbone response and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      err       <= 1'b0;
    end else begin
      wbs_ack_o <= (state_s == ACK);
      if ((state_r == RD_WAIT) && out_valid && !we_r) begin
        wbs_dat_o <= data_out;
      end else if (timeout_s) begin
        wbs_dat_o <= TIMEOUT_DATA;
      end
      if (timeout_s) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Scoreboard bench for sdram_wb_bridge with a behavioural controller model.
module tb_sdram_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [22:0] user_addr;
  logic        rw;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        in_valid;
  logic        out_valid;
  logic        err;

  sdram_wb_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .user_addr(user_addr), .rw(rw), .data_in(data_in), .data_out(data_out),
    .busy(busy), .in_valid(in_valid), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [22:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic is_read; logic [31:0] data; } ack_t;

  wr_t   exp_wr[$];
  ack_t  exp_ack[$];
  logic [31:0] mem [logic [22:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int rd_delay = 3;
  int rd_cnt = 0;
  int iv_count = 0;
  int iv_cyc = 0;
  int acc_cyc = 0;
  int ack_at = 0;
  logic [22:0] exp_rd_addr = 23'h0;
  logic [22:0] rd_addr = 23'h0;
  logic prev_iv = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Controller model and scoreboard consumer, sampled mid-cycle.
  always begin
    @(negedge clk);
    if (rd_cnt > 0) begin
      rd_cnt--;
      out_valid = (rd_cnt == 0);
      data_out  = (rd_cnt == 0) ? mem_rd(rd_addr) : $urandom;
    end else begin
      out_valid = 1'b0;
      data_out  = $urandom;
    end
    #1;
    if (rst_n) begin
      if (in_valid) begin
        iv_count++;
        iv_cyc = cyc_cnt;
        check_val("iv_gap", 32'(prev_iv), 32'd0);
        if (rw) begin
          check_val("wr_pending", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            wr_t e;
            e = exp_wr.pop_front();
            check_val("wr_addr", 32'(user_addr), 32'(e.addr));
            check_val("wr_data", data_in, e.data);
          end
          mem[user_addr] = data_in;
        end else begin
          check_val("rd_addr", 32'(user_addr), 32'(exp_rd_addr));
          rd_addr = user_addr;
          rd_cnt  = rd_delay;
        end
      end
      prev_iv = in_valid;
      if (wbs_ack_o) begin
        check_val("ack_pending", 32'(exp_ack.size() > 0), 32'd1);
        if (exp_ack.size() > 0) begin
          ack_t a;
          a = exp_ack.pop_front();
          if (a.is_read) check_val("rd_data", wbs_dat_o, a.data);
        end
      end
    end else begin
      prev_iv = 1'b0;
      rd_cnt  = 0;
    end
  end

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    exp_rd_addr = {adr[22:2], 2'b00};
    acc_cyc = cyc_cnt;
  endtask

  task automatic wb_wait(input int max, output logic got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        got = 1'b1;
        ack_at = cyc_cnt;
      end
    end
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int max);
    logic got;
    wb_start(we, adr, dat, sel);
    wb_wait(max, got);
    check_val({tag, "_ack"}, 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   ivc;
    rst_n = 1'b0; busy = 1'b0; out_valid = 1'b0; data_out = 32'h0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    #2;
    check_val("rst_ack", 32'(wbs_ack_o), 32'd0);
    check_val("rst_iv", 32'(in_valid), 32'd0);
    check_val("rst_dat", wbs_dat_o, 32'h0);
    check_val("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // full write
    exp_wr.push_back('{23'h000010, 32'h1234_5678});
    exp_ack.push_back('{1'b0, 32'h0});
    wb_xfer("fullwr", 1'b1, 32'h3800_0010, 32'h1234_5678, 4'hF, 20);
    check_val("fullwr_iv_lat", 32'(iv_cyc - acc_cyc), 32'd1);
    check_val("fullwr_ack_lat", 32'(ack_at - acc_cyc), 32'd2);

    // read with response 3 cycles after in_valid
    mem[23'h000010] = 32'hCAFE_F00D;
    rd_delay = 3;
    exp_ack.push_back('{1'b1, 32'hCAFE_F00D});
    wb_xfer("read", 1'b0, 32'h3800_0010, 32'h0, 4'h0, 30);
    check_val("read_iv_lat", 32'(iv_cyc - acc_cyc), 32'd1);
    check_val("read_ack_lat", 32'(ack_at - iv_cyc), 32'd4);
    check_val("read_err", 32'(err), 32'd0);

    // partial write with the documented merge
    mem[23'h000020] = 32'hAABB_CCDD;
    exp_wr.push_back('{23'h000020, 32'hAA22_CC44});
    exp_ack.push_back('{1'b0, 32'h0});
    ivc = iv_count;
    wb_xfer("pwr", 1'b1, 32'h3800_0022, 32'h1122_3344, 4'b0101, 40);
    check_val("pwr_req_count", 32'(iv_count - ivc), 32'd2);
    exp_ack.push_back('{1'b1, 32'hAA22_CC44});
    wb_xfer("pwr_rb", 1'b0, 32'h3800_0020, 32'h0, 4'hF, 30);

    // random partial writes against a mask-based reference
    for (int i = 0; i < 4; i++) begin
      logic [31:0] old_w, dat, mask;
      logic [3:0]  sel;
      logic [22:0] a;
      a = 23'h000100 + 23'(i * 4);
      old_w = $urandom; dat = $urandom; sel = 4'($urandom_range(1, 14));
      mem[a] = old_w;
      rd_delay = $urandom_range(1, 5);
      mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      exp_wr.push_back('{a, (dat & mask) | (old_w & ~mask)});
      exp_ack.push_back('{1'b0, 32'h0});
      wb_xfer("rndpwr", 1'b1, 32'h3800_0000 | 32'(a), dat, sel, 40);
    end

    // sel = 0 write: ack without controller access
    ivc = iv_count;
    exp_ack.push_back('{1'b0, 32'h0});
    wb_xfer("sel0", 1'b1, 32'h3800_0030, 32'h5555_5555, 4'h0, 10);
    check_val("sel0_ack_lat", 32'(ack_at - acc_cyc), 32'd1);
    check_val("sel0_no_iv", 32'(iv_count - ivc), 32'd0);

    // busy stall on a full write
    exp_wr.push_back('{23'h000044, 32'h0BAD_F00D});
    exp_ack.push_back('{1'b0, 32'h0});
    wb_start(1'b1, 32'h3800_0044, 32'h0BAD_F00D, 4'hF);
    busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check_val("stall_iv", 32'(in_valid), 32'd0);
      check_val("stall_ack", 32'(wbs_ack_o), 32'd0);
    end
    @(negedge clk);
    busy = 1'b0;
    #1;
    check_val("stall_release_iv", 32'(in_valid), 32'd1);
    wb_wait(10, got);
    check_val("stall_ack_seen", 32'(got), 32'd1);
    check_val("stall_ack_lat", 32'(ack_at - acc_cyc), 32'd22);

    // read timeout
    rd_delay = 0;
    exp_ack.push_back('{1'b1, 32'hDEAD_BEEF});
    wb_xfer("tmo", 1'b0, 32'h3800_0060, 32'h0, 4'hF, 300);
    check_val("tmo_lat", 32'(ack_at - iv_cyc), 32'd65);
    check_val("tmo_err", 32'(err), 32'd1);

    // outside the window: ignored
    ivc = iv_count;
    wb_start(1'b0, 32'h3900_0000, 32'h0, 4'hF);
    wb_wait(30, got);
    check_val("miss_no_ack", 32'(got), 32'd0);
    check_val("miss_no_iv", 32'(iv_count - ivc), 32'd0);

    // reset during RD_WAIT
    rd_delay = 0;
    wb_start(1'b0, 32'h3800_0050, 32'h0, 4'hF);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mrst_ack", 32'(wbs_ack_o), 32'd0);
    check_val("mrst_iv", 32'(in_valid), 32'd0);
    check_val("mrst_dat", wbs_dat_o, 32'h0);
    check_val("mrst_addr", 32'(user_addr), 32'h0);
    check_val("mrst_rw", 32'(rw), 32'd0);
    check_val("mrst_din", data_in, 32'h0);
    check_val("mrst_err", 32'(err), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_delay = 1;
    exp_ack.push_back('{1'b1, 32'hCAFE_F00D});
    wb_xfer("post_rst_rd", 1'b0, 32'h3800_0010, 32'h0, 4'hF, 30);
    check_val("post_rst_lat", 32'(ack_at - acc_cyc), 32'd3);

    repeat (5) @(negedge clk);
    check_val("exp_wr_left", 32'(exp_wr.size()), 32'd0);
    check_val("exp_ack_left", 32'(exp_ack.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
